program_loader: RTL and testbench

Byte-stream loader that fills the 40-bit instruction memory the fetch path reads by `pc`. It accepts a valid/ready byte stream consisting of a count header followed by big-endian instruction bytes. It assembles each instruction and issues one write per instruction on a write port driving the memory array. It sits between the host/debug byte interface and the instruction memory, and runs only while the core is held off.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 143 ++++++++++++++
 tb/tb_program_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and memory-write signals between program_loader and its host/memory.
// Byte handshake: a byte moves on any rising edge where in_valid && in_ready; the host holds in_data while in_valid is high and unaccepted, and in_ready never depends on in_valid.
interface program_loader_if #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5
);
  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         wr_en;
  logic [PC_WIDTH-1:0]          wr_addr;
  logic [INSTRUCTION_WIDTH-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/program_loader.sv
// Loads big-endian instruction words from a counted byte stream into instruction memory.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int INSTRUCTION_WIDTH = 40,
    parameter int PC_WIDTH          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);
    localparam int NB    = (INSTRUCTION_WIDTH + 7) / 8;
    localparam int DEPTH = 2 ** PC_WIDTH;
    localparam int IW    = PC_WIDTH + 1;
    localparam int BW    = $clog2(NB + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
`ifdef LOADER_CHECKSUM_EN
        , CHK = 3'd5
`endif
    } state_t;

    state_t                       state, state_nx;
    logic [INSTRUCTION_WIDTH-1:0] asm_q;
    logic [IW-1:0]                n_q;
    logic [IW-1:0]                idx_q;
    logic [BW-1:0]                bcnt_q;
    logic                         err_q;
    logic                         take;
    logic                         hdr_bad;
    logic                         last_byte;
    logic                         last_instr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                   csum_q;
`endif

    assign take       = bus.in_valid && bus.in_ready;
    assign hdr_bad    = (bus.in_data == 8'd0) || (32'(bus.in_data) > DEPTH);
    assign last_byte  = (bcnt_q == BW'(NB - 1));
    // Index is one bit wider than the address so a full-depth load ends without wrapping.
    assign last_instr = ((idx_q + IW'(1)) == n_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = HDR;
            HDR:   if (take) state_nx = hdr_bad ? IDLE : DATA;
            DATA:  if (take && last_byte) state_nx = WRITE;
            WRITE: begin
                if (last_instr) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nx = CHK;
`else
                    state_nx = FIN;
`endif
                end else begin
                    state_nx = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:   if (take) state_nx = FIN;
`endif
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q  <= '0;
            n_q    <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
            err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_q  <= 1'b0;
                        idx_q  <= '0;
                        bcnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                    end
                end
                HDR: begin
                    if (take) begin
                        if (hdr_bad) err_q <= 1'b1;
                        else         n_q   <= IW'(bus.in_data);
                    end
                end
                DATA: begin
                    if (take) begin
                        // Excess high bits of the first byte fall off the top after NB shifts.
                        asm_q  <= {asm_q[INSTRUCTION_WIDTH-9:0], bus.in_data};
                        bcnt_q <= last_byte ? '0 : bcnt_q + BW'(1);
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.in_data;
`endif
                    end
                end
                WRITE: idx_q <= idx_q + IW'(1);
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (take && (bus.in_data != csum_q)) err_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign bus.in_ready = (state == HDR) || (state == DATA) || (state == CHK);
`else
    assign bus.in_ready = (state == HDR) || (state == DATA);
`endif
    assign bus.wr_en   = (state == WRITE);
    assign bus.wr_addr = idx_q[PC_WIDTH-1:0];
    assign bus.wr_data = asm_q;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN) && !err_q;
    assign err         = err_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized byte streams against a word-assembly model.
module tb_program_loader;
  localparam int W     = 40;
  localparam int PW    = 5;
  localparam int NB    = (W + 7) / 8;
  localparam int DEPTH = 2 ** PW;
`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_CYC = 1;
`else
  localparam int CHK_CYC = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  program_loader_if #(.INSTRUCTION_WIDTH(W), .PC_WIDTH(PW)) bus ();

  program_loader #(.INSTRUCTION_WIDTH(W), .PC_WIDTH(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [PW+W-1:0] exp_q[$];
  logic [PW+W-1:0] obs_q[$];
  logic [7:0]      stim_q[$];
  int done_cnt;
  int busy_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en === 1'b1) begin
        obs_q.push_back({bus.wr_addr, bus.wr_data});
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bubble: in_ready=%b during wr_en, required 0", bus.in_ready);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    stim_q.delete();
    done_cnt = 0;
    busy_cyc = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int t;
    int g;
    t = 0;
    if (gappy) begin
      g = $urandom_range(0, 3);
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b, required 0", busy);
    end
  endtask

  // Sends a full load of stim_q and records the expected writes from the plain byte-to-word rule.
  task automatic send_stream(input logic [7:0] hdr, input bit gappy,
                             input logic [7:0] chk_flip, input int start_at);
    logic [7:0]  x;
    logic [63:0] w;
    logic [PW-1:0] a;
    x = 8'h00;
    pulse_start();
    send_byte(hdr, gappy);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == start_at) start = 1'b1;
      send_byte(stim_q[i], gappy);
      start = 1'b0;
      x = x ^ stim_q[i];
    end
`ifdef LOADER_CHECKSUM_EN
    if (stim_q.size() > 0) send_byte(x ^ chk_flip, gappy);
`else
    x = x ^ chk_flip;
`endif
    wait_idle();
    for (int i = 0; i < stim_q.size() / NB; i++) begin
      w = 64'd0;
      for (int j = 0; j < NB; j++) w = (w << 8) | 64'(stim_q[i*NB + j]);
      a = PW'(i);
      exp_q.push_back({a, w[W-1:0]});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.wr_en, busy, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: {rdy,wr,busy,done,err}=%b, required 00000",
               {bus.in_ready, bus.wr_en, busy, done, err});
    end
    n_cmp++;
    if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h data=%h, required 0 0", bus.wr_addr, bus.wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, busy, done, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: {rdy,busy,done,err}=%b, required 0000",
               {bus.in_ready, busy, done, err});
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[15] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                          8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E,
                          8'hFF, 8'h00, 8'h11, 8'h22, 8'h33};
    clear_sb();
    foreach (b[i]) stim_q.push_back(b[i]);
    send_stream(8'd3, 1'b0, 8'h00, -1);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: got %h, required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done pulses=%0d err=%b, required 1 0", done_cnt, err);
    end
    n_cmp++;
    if (busy_cyc !== 2 + 3 * (NB + 1) + CHK_CYC) begin
      n_fail++;
      $display("FAIL basic_cycles: busy cycles=%0d, required %0d", busy_cyc,
               2 + 3 * (NB + 1) + CHK_CYC);
    end
  endtask

  task automatic test_bad_header();
    logic [7:0] hdrs[2] = '{8'h00, 8'(DEPTH + 1)};
    foreach (hdrs[k]) begin
      clear_sb();
      pulse_start();
      send_byte(hdrs[k], 1'b0);
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL badhdr_%h: err=%b busy=%b, required 1 0", hdrs[k], err, busy);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs_q.size() !== 0 || done_cnt !== 0 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL badhdr_quiet_%h: writes=%0d done=%0d err=%b, required 0 0 1",
                 hdrs[k], obs_q.size(), done_cnt, err);
      end
      pulse_start();
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL badhdr_clear_%h: err=%b busy=%b, required 0 1", hdrs[k], err, busy);
      end
      send_byte(8'h00, 1'b0);
      wait_idle();
    end
  endtask

  task automatic test_full_depth();
    clear_sb();
    for (int i = 0; i < DEPTH * NB; i++) stim_q.push_back(8'($urandom));
    send_stream(8'(DEPTH), 1'b1, 8'h00, -1);
    n_cmp++;
    if (obs_q.size() !== DEPTH) begin
      n_fail++;
      $display("FAIL full_count: writes=%0d, required %0d", obs_q.size(), DEPTH);
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL full_write%0d: got %h, required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done pulses=%0d err=%b, required 1 0", done_cnt, err);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] flips[2] = '{8'h00, 8'h01};
    foreach (flips[k]) begin
      clear_sb();
      for (int i = 1; i <= 5; i++) stim_q.push_back(8'(i));
      send_stream(8'd1, 1'b0, flips[k], -1);
      n_cmp++;
      if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL chk_write_%0d: writes=%0d word=%h, required 1 %h", k, obs_q.size(),
                 (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
      end
      n_cmp++;
      if (err !== (flips[k] != 8'h00) || done_cnt !== ((flips[k] != 8'h00) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL chk_result_%0d: err=%b done=%0d, required %b %0d", k, err, done_cnt,
                 (flips[k] != 8'h00), (flips[k] != 8'h00) ? 0 : 1);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [63:0] w;
    clear_sb();
    for (int i = 0; i < 2 * NB; i++) stim_q.push_back(8'($urandom));
    w = 64'd0;
    for (int j = 0; j < NB; j++) w = (w << 8) | 64'(stim_q[j]);
    exp_q.push_back({PW'(0), w[W-1:0]});
    pulse_start();
    send_byte(8'd2, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(stim_q[i], 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.wr_en, busy, done, err} !== 5'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: {rdy,wr,busy,done,err}=%b addr=%h data=%h, required 0",
               {bus.in_ready, bus.wr_en, busy, done, err}, bus.wr_addr, bus.wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL midreset_partial: writes=%0d word=%h, required 1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
    clear_sb();
    for (int i = 0; i < NB; i++) stim_q.push_back(8'($urandom));
    send_stream(8'd1, 1'b1, 8'h00, -1);
    n_cmp++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0] || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL midreset_reload: writes=%0d word=%h done=%0d, required 1 %h 1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0], done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    clear_sb();
    for (int i = 0; i < 2 * NB; i++) stim_q.push_back(8'($urandom));
    send_stream(8'd2, 1'b0, 8'h00, 3);
    n_cmp++;
    if (obs_q.size() !== 2) begin
      n_fail++;
      $display("FAIL start_count: writes=%0d, required 2", obs_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_write%0d: got %h, required %h", i,
                 (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || busy_cyc !== 2 + 2 * (NB + 1) + CHK_CYC) begin
      n_fail++;
      $display("FAIL start_done: done=%0d busy cycles=%0d, required 1 %0d", done_cnt, busy_cyc,
               2 + 2 * (NB + 1) + CHK_CYC);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst          = 1'b1;
    done_cnt     = 0;
    busy_cyc     = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_bad_header();
    test_full_depth();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    test_start_ignored();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
